variable_node_unit: RTL

Variable-node processor for the min-sum LDPC decoder, the counterpart of the check-node unit on the same edge bus. It holds one channel LLR and exchanges per-edge messages with `weight` check nodes. Each iteration it sums the channel value and all incoming check messages, produces the saturated extrinsic message for every edge, and reports a hard-decision bit.

---
 rtl/variable_node_unit_if.sv | 30 +++
 rtl/variable_node_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/variable_node_unit_if.sv
// Edge bus between a variable-node unit and its check nodes, plus the
// channel-load and stop controls that drive each frame.
interface variable_node_unit_if #(
  parameter int weight = 3,
  parameter int length = 15
);
  logic [length-1:0]        channel_value_input;
  logic                     channel_load;
  logic                     decision_success;
  logic [weight*length-1:0] check_value_input;
  logic [weight-1:0]        check_enable_input;
  logic [weight*length-1:0] variable_value_output;
  logic [weight-1:0]        variable_enable_output;
  logic                     decision_bit;
  logic                     decision_valid;

  modport master (
    output channel_value_input, channel_load, decision_success,
           check_value_input, check_enable_input,
    input  variable_value_output, variable_enable_output,
           decision_bit, decision_valid
  );

  modport slave (
    input  channel_value_input, channel_load, decision_success,
           check_value_input, check_enable_input,
    output variable_value_output, variable_enable_output,
           decision_bit, decision_valid
  );
endinterface

// File: rtl/variable_node_unit.sv
// Min-sum LDPC variable node: sums the channel LLR with all check messages and
// returns one symmetrically saturated extrinsic message per edge, serially.
module variable_node_unit #(
  parameter int weight = 3,
  parameter int length = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  variable_node_unit_if.slave  bus
);
  localparam int ACC_W = length + $clog2(weight + 1) + 1;
  localparam int JW    = (weight > 1) ? $clog2(weight) : 1;
  localparam logic [JW-1:0] J_LAST = JW'(weight - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (length - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_CHECK, SUM, UPDATE} state_t;

  state_t                   state, state_nxt;
  logic signed [length-1:0] chan;
  logic signed [length-1:0] chk [weight];
  logic signed [ACC_W-1:0]  acc;
  logic [JW-1:0]            j;
  logic                     armed;
  logic signed [length-1:0] v_msg [weight];
  logic [weight-1:0]        v_en;
  logic                     dec_bit;
  logic                     dec_vld;
  logic                     all_en;
  logic                     trigger;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [length-1:0] x);
    return {{(ACC_W - length){x[length-1]}}, x};
  endfunction

  // Symmetric clamp: the most-negative code is never produced.
  function automatic logic signed [length-1:0] sat(input logic signed [ACC_W-1:0] x);
    if (x > SAT_HI) return SAT_HI[length-1:0];
    if (x < SAT_LO) return SAT_LO[length-1:0];
    return x[length-1:0];
  endfunction

  assign all_en  = &bus.check_enable_input;
  assign trigger = (state == WAIT_CHECK) && !bus.channel_load &&
                   !bus.decision_success && armed && all_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.channel_load) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        IDLE:       state_nxt = IDLE;
        LOAD:       state_nxt = WAIT_CHECK;
        WAIT_CHECK: begin
          if (bus.decision_success) state_nxt = IDLE;
          else if (trigger)         state_nxt = SUM;
        end
        SUM:        if (j == J_LAST) state_nxt = UPDATE;
        UPDATE:     if (j == J_LAST) state_nxt = WAIT_CHECK;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  // Message storage carries no reset; it is always written before use.
  always_ff @(posedge clk) begin
    if (bus.channel_load) chan <= bus.channel_value_input;
    if (trigger) begin
      for (int k = 0; k < weight; k++)
        chk[k] <= bus.check_value_input[k*length +: length];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      j       <= '0;
      armed   <= 1'b0;
      v_en    <= '0;
      dec_bit <= 1'b0;
      dec_vld <= 1'b0;
      for (int k = 0; k < weight; k++) v_msg[k] <= '0;
    end else begin
      dec_vld <= 1'b0;
      if (bus.channel_load) begin
        j <= '0;
      end else begin
        case (state)
          LOAD: begin
            for (int k = 0; k < weight; k++) v_msg[k] <= sat(sext(chan));
            v_en  <= '1;
            armed <= 1'b0;
            j     <= '0;
          end
          WAIT_CHECK: begin
            // A low enable bit re-arms, so a held all-ones bus cannot retrigger.
            if (!all_en) armed <= 1'b1;
            if (trigger) begin
              acc  <= sext(chan);
              j    <= '0;
              v_en <= '0;
            end
          end
          SUM: begin
            acc <= acc + sext(chk[j]);
            j   <= (j == J_LAST) ? '0 : j + JW'(1);
          end
          UPDATE: begin
            v_msg[j] <= sat(acc - sext(chk[j]));
            v_en[j]  <= 1'b1;
            if (j == '0) begin
              dec_bit <= acc[ACC_W-1];
              dec_vld <= 1'b1;
            end
            if (j == J_LAST) begin
              j     <= '0;
              armed <= 1'b0;
            end else begin
              j <= j + JW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < weight; g++) begin : g_pack
    assign bus.variable_value_output[g*length +: length] = v_msg[g];
  end
  assign bus.variable_enable_output = v_en;
  assign bus.decision_bit           = dec_bit;
  assign bus.decision_valid         = dec_vld;
endmodule
